strobe_decimator: RTL

- Parametrised, multi-channel successor to the fixed decimate-by-8 strobe picker.
- Accepts CHANNELS packed signed samples qualified by `strobe_in`.
- Emits one output per N input strobes, where N is runtime-programmable, in one of two modes: sample-pick or integrate-and-dump with shift and saturation.
- Sits in sdr_lib between the CIC/halfband chain and the packet/FIFO interface; its output strobe feeds downstream stages the same way `strobe_in` feeds this block.

---
 rtl/sdr_decim_pkg.sv | 29 ++
 rtl/decim_channel.sv | 51 +++++
 rtl/strobe_decimator.sv | 92 +++++++++
 3 files changed

// File: rtl/sdr_decim_pkg.sv
// Shared constants and the shift/clamp/saturate helper for the strobe decimator.
package sdr_decim_pkg;

  localparam logic DECIM_PICK  = 1'b0;
  localparam logic DECIM_INTEG = 1'b1;

  // Arithmetic right shift by min(shift, max_shift), then saturate to a
  // signed out_w-bit range. Width is a call argument so one function serves
  // any channel width; with constant arguments it folds to plain logic.
  function automatic logic signed [63:0] sat_shift(
    input logic signed [63:0] acc,
    input logic [4:0]         shift,
    input int unsigned        max_shift,
    input int unsigned        out_w
  );
    logic [4:0]         sh;
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = (32'(shift) > max_shift) ? 5'(max_shift) : shift;
    v  = acc >>> sh;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      sat_shift = hi;
    else if (v < lo) sat_shift = lo;
    else             sat_shift = v;
  endfunction

endpackage

// File: rtl/decim_channel.sv
// One decimator lane: pick capture, integrate-and-dump accumulator, output register.
module decim_channel
  import sdr_decim_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RATE_BITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic             grp_start,
  input  logic             grp_end,
  input  logic             mode,
  input  logic [4:0]       shift,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = WIDTH + RATE_BITS;

  logic [WIDTH-1:0]     cap;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_nxt;
  logic signed [AW-1:0] sample_ext;
  logic [WIDTH-1:0]     pick_val;
  logic [WIDTH-1:0]     integ_val;

  // Running sum including the current sample, so the group-end strobe's own
  // sample lands in the dumped result without an extra cycle.
  always_comb begin
    sample_ext = {{RATE_BITS{sample[WIDTH-1]}}, sample};
    acc_nxt    = grp_start ? sample_ext : acc + sample_ext;
    pick_val   = grp_start ? sample : cap;
    integ_val  = WIDTH'(sat_shift({{(64-AW){acc_nxt[AW-1]}}, acc_nxt}, shift,
                                  RATE_BITS, WIDTH));
  end

  // Capture/accumulate on input strobes; update output only at group end.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap  <= '0;
      acc  <= '0;
      dout <= '0;
    end else if (strobe) begin
      if (grp_start) cap <= sample;
      acc <= acc_nxt;
      if (grp_end) dout <= (mode == DECIM_INTEG) ? integ_val : pick_val;
    end
  end

endmodule

// File: rtl/strobe_decimator.sv
// Multi-channel strobe decimator: shared group counter and shadow controls,
// one decim_channel per channel.
module strobe_decimator
  import sdr_decim_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CHANNELS  = 2,
  parameter int RATE_BITS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      strobe_in,
  input  logic [CHANNELS*WIDTH-1:0] datain,
  input  logic [RATE_BITS-1:0]      rate,
  input  logic                      mode,
  input  logic [4:0]                shift,
  output logic [CHANNELS*WIDTH-1:0] dataout,
  output logic                      strobe_out
);

  logic [RATE_BITS-1:0] cnt;
  logic [RATE_BITS-1:0] rate_sh;
  logic                 mode_sh;
  logic [4:0]           shift_sh;

  logic [RATE_BITS-1:0] rate_eff;
  logic [RATE_BITS-1:0] last_idx;
  logic                 mode_eff;
  logic [4:0]           shift_eff;
  logic                 at_start;
  logic                 grp_start;
  logic                 grp_end;

  logic [CHANNELS-1:0][WIDTH-1:0] din_ch;
  logic [CHANNELS-1:0][WIDTH-1:0] dout_ch;

  // At cnt==0 the live controls apply (they are being latched this strobe),
  // which is what makes N=1 groups start and end on the same strobe.
  always_comb begin
    at_start  = (cnt == '0);
    rate_eff  = at_start ? rate  : rate_sh;
    mode_eff  = at_start ? mode  : mode_sh;
    shift_eff = at_start ? shift : shift_sh;
    last_idx  = (rate_eff < RATE_BITS'(2)) ? '0 : rate_eff - RATE_BITS'(1);
    grp_start = strobe_in && at_start;
    grp_end   = strobe_in && (cnt == last_idx);
  end

  // Group counter and control shadows, advanced only by input strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      rate_sh  <= '0;
      mode_sh  <= DECIM_PICK;
      shift_sh <= '0;
    end else if (strobe_in) begin
      cnt <= grp_end ? '0 : cnt + RATE_BITS'(1);
      if (grp_start) begin
        rate_sh  <= rate;
        mode_sh  <= mode;
        shift_sh <= shift;
      end
    end
  end

  // Output strobe follows the group-end strobe by one clock.
  always_ff @(posedge clk) begin
    if (reset) strobe_out <= 1'b0;
    else       strobe_out <= grp_end;
  end

  assign din_ch  = datain;
  assign dataout = dout_ch;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    decim_channel #(
      .WIDTH     (WIDTH),
      .RATE_BITS (RATE_BITS)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .strobe    (strobe_in),
      .grp_start (grp_start),
      .grp_end   (grp_end),
      .mode      (mode_eff),
      .shift     (shift_eff),
      .sample    (din_ch[k]),
      .dout      (dout_ch[k])
    );
  end

endmodule
